// File: rtl/tlv5618_pkg.sv
// Shared constants and state encoding for the TLV5618 serial-link frame receiver.
package tlv5618_pkg;

    localparam int FRAME_BITS_DEF  = 16;
    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int WORD_W          = 16;
    localparam int CODE_W          = 12;

    // {R1,R0} register-select field of a TLV5618 control word
    localparam logic [1:0] REG_B_BUF = 2'b00;
    localparam logic [1:0] REG_BUF   = 2'b01;
    localparam logic [1:0] REG_A_UPD = 2'b10;
    localparam logic [1:0] REG_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; clears to 0 on reset.
module sync_2ff (
    input  logic Clk,
    input  logic Rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tlv5618_frame_rx.sv
// Oversampling receiver for the TLV5618 SCLK/DIN/CS_n link, mirroring the DAC A/B latches and buffer.
// Optional build macro FRAME_RX_ERR_CNT_EN adds the saturating error counter output Out_Err_Cnt.
module tlv5618_frame_rx
    import tlv5618_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              In_SCLK,
    input  logic              In_Din,
    input  logic              In_CS_n,
    output logic              Out_Frame_Valid,
    output logic              Out_Frame_Err,
    output logic [WORD_W-1:0] Out_Word,
    output logic [CODE_W-1:0] Out_Chn_A_Code,
    output logic [CODE_W-1:0] Out_Chn_B_Code,
    output logic [CODE_W-1:0] Out_Buf_Code,
    output logic              Out_Speed_Fast,
    output logic              Out_Power_Down
`ifdef FRAME_RX_ERR_CNT_EN
    ,
    output logic [7:0]        Out_Err_Cnt
`endif
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    rx_state_t         state, state_nxt;
    logic              sclk_s, din_s, cs_s;
    logic              sclk_d, cs_d;
    logic              sclk_fall, cs_fall, cs_rise;
    logic [WORD_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TMR_W-1:0]  timer;
    logic [1:0]        reg_sel;
    logic              frame_ok;
    logic              valid_nxt, err_nxt;

    sync_2ff u_sync_sclk (.Clk(Clk), .Rst_n(Rst_n), .d(In_SCLK), .q(sclk_s));
    sync_2ff u_sync_din  (.Clk(Clk), .Rst_n(Rst_n), .d(In_Din),  .q(din_s));
    sync_2ff u_sync_cs   (.Clk(Clk), .Rst_n(Rst_n), .d(In_CS_n), .q(cs_s));

    // CS_n synchroniser clears low, so a frame already running at reset release shows no falling edge
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_fall = sclk_d & ~sclk_s;
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign reg_sel   = {shift_reg[15], shift_reg[12]};
    assign frame_ok  = (bit_cnt == CNT_W'(FRAME_BITS)) && (reg_sel != REG_RSVD);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE:  if (cs_fall) state_nxt = SHIFT;
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = DONE;
                end else if (timer == TMR_W'(TIMEOUT_CYC)) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (frame_ok) valid_nxt = 1'b1;
                else          err_nxt   = 1'b1;
            end
            ERR:   if (cs_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A bit sampled in the same cycle as CS_n rising is already in shift_reg when DONE evaluates
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        timer     <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        shift_reg <= {shift_reg[WORD_W-2:0], din_s};
                        if (bit_cnt != CNT_W'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    if (timer != TMR_W'(TIMEOUT_CYC)) timer <= timer + TMR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // B takes the pre-update buffer value when an A-update word arrives
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Out_Frame_Valid <= 1'b0;
            Out_Frame_Err   <= 1'b0;
            Out_Word        <= '0;
            Out_Chn_A_Code  <= '0;
            Out_Chn_B_Code  <= '0;
            Out_Buf_Code    <= '0;
            Out_Speed_Fast  <= 1'b0;
            Out_Power_Down  <= 1'b0;
        end else begin
            Out_Frame_Valid <= valid_nxt;
            Out_Frame_Err   <= err_nxt;
            if (valid_nxt) begin
                Out_Word       <= shift_reg;
                Out_Speed_Fast <= shift_reg[14];
                Out_Power_Down <= shift_reg[13];
                case (reg_sel)
                    REG_B_BUF: begin
                        Out_Chn_B_Code <= shift_reg[CODE_W-1:0];
                        Out_Buf_Code   <= shift_reg[CODE_W-1:0];
                    end
                    REG_BUF:   Out_Buf_Code <= shift_reg[CODE_W-1:0];
                    REG_A_UPD: begin
                        Out_Chn_A_Code <= shift_reg[CODE_W-1:0];
                        Out_Chn_B_Code <= Out_Buf_Code;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FRAME_RX_ERR_CNT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                              Out_Err_Cnt <= 8'd0;
        else if (err_nxt && Out_Err_Cnt != 8'hFF) Out_Err_Cnt <= Out_Err_Cnt + 8'd1;
    end
`endif

endmodule
